// File: rtl/rf16_access_arbiter_pkg.sv
// rtl/rf16_access_arbiter_pkg.sv - shared types, default widths and round-robin helper for the bank arbiter
package rf16_access_arbiter_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int RID_W      = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Pointer to the requester after idx, wrapping at num_req.
   function automatic logic [RID_W-1:0] rr_next(input logic [RID_W-1:0] idx, input int num_req);
      rr_next = RID_W'((int'(idx) + 1) % num_req);
   endfunction

endpackage

// File: rtl/rf16_access_arbiter_if.sv
// rtl/rf16_access_arbiter_if.sv - requester-side bus of the arbiter; RF16_BURST_LOCK_EN adds the lock vector
interface rf16_access_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        wr;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        grant;
   logic [DATA_W-1:0]         rdata;
   logic                      rvalid;
   logic [1:0]                rid;
   logic                      busy;
`ifdef RF16_BURST_LOCK_EN
   logic [NUM_REQ-1:0]        lock;

   modport master (output req, wr, addr, wdata, lock, input grant, rdata, rvalid, rid, busy);
   modport slave  (input req, wr, addr, wdata, lock, output grant, rdata, rvalid, rid, busy);
`else
   modport master (output req, wr, addr, wdata, input grant, rdata, rvalid, rid, busy);
   modport slave  (input req, wr, addr, wdata, output grant, rdata, rvalid, rid, busy);
`endif
endinterface

// File: rtl/rf16_rr_pick.sv
// rtl/rf16_rr_pick.sv - combinational round-robin winner search starting at rr_ptr with wrap
module rf16_rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_rr_ptr,
   output logic [1:0]         o_winner,
   output logic               o_valid
);

   // Scan distances from far to near so the nearest set request is the last assignment.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == (int'(i_rr_ptr) + k) % NUM_REQ) && i_req[i]) begin
               o_winner = 2'(i);
               o_valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rf16_access_arbiter.sv
// rtl/rf16_access_arbiter.sv - IDLE/ACCESS/DONE sequencer sharing one register bank among requesters
// Optional burst lock build: RF16_BURST_LOCK_EN
module rf16_access_arbiter
   import rf16_access_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   rf16_access_arbiter_if.slave  io_bus,
   output logic                  o_rf_we,
   output logic [ADDR_W-1:0]     o_rf_addr,
   output logic [DATA_W-1:0]     o_rf_wdata,
   input  logic [DATA_W-1:0]     i_rf_rdata
);

   state_t              r_state;
   state_t              w_next_state;
   logic [1:0]          r_rr_ptr;
   logic [1:0]          r_rid;
   logic                r_is_read;
   logic [NUM_REQ-1:0]  r_grant;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rvalid;

   logic [1:0]          w_winner;
   logic                w_valid;
   logic [NUM_REQ-1:0]  w_grant_next;
   logic                w_sel_wr;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
`ifdef RF16_BURST_LOCK_EN
   logic                w_own_req;
   logic                w_own_lock;
`endif

   rf16_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_req    (io_bus.req),
      .i_rr_ptr (r_rr_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   // Route the winner's request fields, and the current owner's req/lock, out of the packed buses.
   always_comb begin
      w_grant_next = '0;
      w_sel_wr     = 1'b0;
      w_sel_addr   = '0;
      w_sel_wdata  = '0;
`ifdef RF16_BURST_LOCK_EN
      w_own_req    = 1'b0;
      w_own_lock   = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(w_winner) == i) begin
            w_grant_next[i] = 1'b1;
            w_sel_wr        = io_bus.wr[i];
            w_sel_addr      = io_bus.addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata     = io_bus.wdata[i*DATA_W +: DATA_W];
         end
`ifdef RF16_BURST_LOCK_EN
         if (int'(r_rid) == i) begin
            w_own_req  = io_bus.req[i];
            w_own_lock = io_bus.lock[i];
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_valid) w_next_state = ST_ACCESS;
         ST_ACCESS: w_next_state = ST_DONE;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr  <= '0;
         r_rid     <= '0;
         r_is_read <= 1'b0;
         r_grant   <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_addr    <= w_sel_addr;
                  r_wdata   <= w_sel_wdata;
                  r_we      <= w_sel_wr;
                  r_is_read <= ~w_sel_wr;
                  r_grant   <= w_grant_next;
                  r_rid     <= w_winner;
               end
            end
            ST_ACCESS: begin
               r_we     <= 1'b0;
               r_grant  <= '0;
               r_rr_ptr <= rr_next(r_rid, NUM_REQ);
               if (r_is_read) begin
                  r_rdata  <= i_rf_rdata;
                  r_rvalid <= 1'b1;
               end
            end
            ST_DONE: begin
               r_rvalid <= 1'b0;
`ifdef RF16_BURST_LOCK_EN
               // Pull the pointer back so the locked owner wins the next selection.
               if (w_own_lock && w_own_req) r_rr_ptr <= r_rid;
`endif
            end
            default: ;
         endcase
      end
   end

   assign io_bus.grant  = r_grant;
   assign io_bus.rdata  = r_rdata;
   assign io_bus.rvalid = r_rvalid;
   assign io_bus.rid    = r_rid;
   assign io_bus.busy   = (r_state != ST_IDLE);
   assign o_rf_we       = r_we;
   assign o_rf_addr     = r_addr;
   assign o_rf_wdata    = r_wdata;

endmodule

// File: tb/tb_rf16_access_arbiter.sv
// tb/tb_rf16_access_arbiter.sv - directed and random bench with a transaction-level model of the arbiter and bank
`timescale 1ns/1ps
module tb_rf16_access_arbiter;
   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rf16_access_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata;
   logic [DATA_W-1:0] bank [8];

   rf16_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .io_bus     (bus),
      .o_rf_we    (rf_we),
      .o_rf_addr  (rf_addr),
      .o_rf_wdata (rf_wdata),
      .i_rf_rdata (rf_rdata)
   );

   assign rf_rdata = bank[rf_addr];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) for (int i = 0; i < 8; i++) bank[i] <= '0;
      else if (rf_we) bank[rf_addr] <= rf_wdata;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Requester agents
   logic [NUM_REQ-1:0] pend = '0;
   logic [NUM_REQ-1:0] hold = '0;
   logic               p_wr   [NUM_REQ];
   logic [ADDR_W-1:0]  p_addr [NUM_REQ];
   logic [DATA_W-1:0]  p_data [NUM_REQ];
   int                 glog [$];

   task automatic drive_bus();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req[i] = pend[i];
         bus.wr[i]  = p_wr[i];
         bus.addr[i*ADDR_W +: ADDR_W]  = p_addr[i];
         bus.wdata[i*DATA_W +: DATA_W] = p_data[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.grant[i]) begin
            glog.push_back(i);
            if (!hold[i]) pend[i] = 1'b0;
         end
      end
      drive_bus();
   endtask

   task automatic post_req(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pend[i] = 1'b1; p_wr[i] = w; p_addr[i] = a; p_data[i] = d;
      drive_bus();
   endtask

   task automatic wait_idle(input string tag);
      int ok = 0;
      for (int n = 0; n < 100; n++) begin
         if (pend == 0 && hold == 0 && !bus.busy) begin ok = 1; break; end
         tick();
      end
      chk(tag, ok, 1);
   endtask

   task automatic wr_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      post_req(i, 1'b1, a, d);
      wait_idle("wr_done");
   endtask

   task automatic rd_expect(input string tag, input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      int got = 0;
      post_req(i, 1'b0, a, '0);
      for (int n = 0; n < 20; n++) begin
         tick();
         if (bus.rvalid && bus.rid == 2'(i)) begin got = 1; break; end
      end
      chk({tag, "_seen"}, got, 1);
      chk(tag, bus.rdata, exp);
   endtask

   // Transaction-level reference: one access per IDLE selection, writes land after ACCESS.
   int                 m_phase, m_ptr, m_w;
   logic               m_wr;
   logic [ADDR_W-1:0]  m_addr;
   logic [DATA_W-1:0]  m_data;
   logic [DATA_W-1:0]  mem [8];
   logic [NUM_REQ-1:0] e_grant;
   logic               e_busy, e_rvalid, e_we;
   logic [DATA_W-1:0]  e_rdata;
   logic [1:0]         e_rid;

   function automatic int ref_pick(input logic [NUM_REQ-1:0] r, input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         m_phase = 0; m_ptr = 0; m_w = 0; m_wr = 0; m_addr = '0; m_data = '0;
         e_grant = '0; e_busy = 0; e_rvalid = 0; e_we = 0; e_rdata = '0; e_rid = '0;
         for (int i = 0; i < 8; i++) mem[i] = '0;
      end else begin
         chk("grant", bus.grant, e_grant);
         chk("busy", bus.busy, e_busy);
         chk("rvalid", bus.rvalid, e_rvalid);
         chk("rdata", bus.rdata, e_rdata);
         chk("rf_we", rf_we, e_we);
         if (e_grant != 0) chk("rf_addr", rf_addr, m_addr);
         if (e_we) chk("rf_wdata", rf_wdata, m_data);
         if (e_rvalid) chk("rid", bus.rid, e_rid);
         case (m_phase)
            0: begin
               e_rvalid = 0;
               if (bus.req != 0) begin
                  m_w    = ref_pick(bus.req, m_ptr);
                  m_wr   = bus.wr[m_w];
                  m_addr = bus.addr[m_w*ADDR_W +: ADDR_W];
                  m_data = bus.wdata[m_w*DATA_W +: DATA_W];
                  e_grant = '0; e_grant[m_w] = 1'b1;
                  e_we = m_wr; e_busy = 1; m_phase = 1;
               end else begin
                  e_grant = '0; e_we = 0; e_busy = 0;
               end
            end
            1: begin
               e_grant = '0; e_we = 0; e_busy = 1;
               m_ptr = (m_w + 1) % NUM_REQ;
               if (m_wr) mem[m_addr] = m_data;
               else begin e_rvalid = 1; e_rdata = mem[m_addr]; e_rid = 2'(m_w); end
               m_phase = 2;
            end
            default: begin
               e_rvalid = 0; e_busy = 0;
`ifdef RF16_BURST_LOCK_EN
               if (bus.lock[m_w] && bus.req[m_w]) m_ptr = m_w;
`endif
               m_phase = 0;
            end
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin p_wr[i] = 0; p_addr[i] = '0; p_data[i] = '0; end
`ifdef RF16_BURST_LOCK_EN
      bus.lock = '0;
`endif
      drive_bus();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_grant", bus.grant, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rid", bus.rid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      @(posedge clk); #2;
      reset_n = 1'b1;

      // Single write then read back
      post_req(0, 1'b1, 3'd3, 16'hA5C3);
      tick();
      chk("wr3_grant_c1", bus.grant, 3'b001);
      chk("wr3_we_hi", rf_we, 1);
      tick();
      chk("wr3_we_lo", rf_we, 0);
      chk("wr3_bank", bank[3], 16'hA5C3);
      wait_idle("wr3_idle");
      rd_expect("rd3", 0, 3'd3, 16'hA5C3);
      wait_idle("rd3_idle");

      // Top address, then an untouched word, then re-read
      wr_req(1, 3'd7, 16'hFFFF);
      rd_expect("rd0_init", 1, 3'd0, 16'h0000);
      wait_idle("rd0_idle");
      rd_expect("rd7", 0, 3'd7, 16'hFFFF);
      wait_idle("rd7_idle");

      // Request arriving in DONE is served on the following selection
      post_req(0, 1'b1, 3'd2, 16'h1234);
      tick(); tick();
      post_req(1, 1'b0, 3'd2, '0);
      tick(); tick();
      chk("queued_grant", bus.grant, 3'b010);
      tick();
      chk("queued_rdata", bus.rdata, 16'h1234);
      wait_idle("queued_idle");

      // Two held readers alternate
      hold = 3'b011; pend = 3'b011;
      p_wr[0] = 0; p_addr[0] = 3'd3; p_wr[1] = 0; p_addr[1] = 3'd7;
      drive_bus();
      glog.delete();
      for (int n = 0; n < 13; n++) tick();
      chk("rr_count", glog.size() >= 4, 1);
      for (int k = 1; k < glog.size(); k++) chk("rr_alt", glog[k], 1 - glog[k-1]);

`ifdef RF16_BURST_LOCK_EN
      bus.lock = 3'b010;
      glog.delete();
      for (int n = 0; n < 15; n++) tick();
      begin
         int f = -1;
         for (int k = 0; k < glog.size(); k++) if (glog[k] == 1 && f < 0) f = k;
         chk("lock_first", (f >= 0 && f + 2 < glog.size()), 1);
         if (f >= 0 && f + 2 < glog.size()) begin
            chk("lock_g2", glog[f+1], 1);
            chk("lock_g3", glog[f+2], 1);
         end
      end
      begin
         int ok = 0;
         for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.grant[1]) begin ok = 1; break; end
         end
         chk("lock_g1_seen", ok, 1);
      end
      bus.lock = '0;
      glog.delete();
      for (int n = 0; n < 4; n++) tick();
      chk("unlock_next", (glog.size() > 0) ? glog[0] : -1, 0);
`endif
      hold = '0; pend = '0;
      drive_bus();
      wait_idle("rr_idle");

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         tick();
         for (int i = 0; i < NUM_REQ; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0)
               post_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
`ifdef RF16_BURST_LOCK_EN
         if ($urandom_range(0, 7) == 0) bus.lock = 3'($urandom_range(0, 7));
`endif
      end
`ifdef RF16_BURST_LOCK_EN
      bus.lock = '0;
`endif
      wait_idle("rand_drain");

      // Reset during the ACCESS cycle of a write
      post_req(2, 1'b1, 3'd5, 16'h5A5A);
      tick();
      chk("mid_we_hi", rf_we, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_grant", bus.grant, 0);
      chk("mid_we", rf_we, 0);
      chk("mid_rvalid", bus.rvalid, 0);
      chk("mid_busy", bus.busy, 0);
      pend = '0; hold = '0; glog.delete();
      drive_bus();
      tick(); tick();
      reset_n = 1'b1;
      post_req(0, 1'b0, 3'd1, '0);
      post_req(1, 1'b0, 3'd2, '0);
      tick();
      chk("post_rst_ptr0", bus.grant, 3'b001);
      wait_idle("final_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
